// File: rtl/approx_mult_pkg.sv
// Shared constants and the result record type for the approximate-multiplier
// error monitor family.
package approx_mult_pkg;

    localparam int DEF_W      = 8;
    localparam int PROD_W     = 2 * DEF_W;
    localparam int DEF_ACC_W  = 32;
    localparam int DEF_WINDOW = 256;
    localparam int CNT_W      = 16;

    // Record layout at the default widths.
    typedef struct packed {
        logic [DEF_ACC_W-1:0] sum_ed;
        logic [DEF_ACC_W:0]   sum_se;
        logic [PROD_W-1:0]    max_ed;
        logic [CNT_W-1:0]     err_cnt;
    } err_rec_t;

endpackage

// File: rtl/approx_mult_err_monitor_err_calc.sv
// Signed difference z - exact (one extra bit) and its magnitude.
module err_calc #(
    parameter int PW = 16
) (
    input  logic [PW-1:0] z,
    input  logic [PW-1:0] exact,
    output logic [PW:0]   d,
    output logic [PW-1:0] ed
);

    assign d  = {1'b0, z} - {1'b0, exact};
    // Magnitude always fits in PW bits, so subtract in the right order instead of negating d.
    assign ed = d[PW] ? (exact - z) : (z - exact);

endmodule

// File: rtl/approx_mult_err_monitor.sv
// Windowed error statistics for an unsigned WxW approximate multiplier:
// one S1 register stage (exact product), one S2 accumulate stage, result on valid/ready.
module approx_mult_err_monitor
    import approx_mult_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int WINDOW = DEF_WINDOW,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       x,
    input  logic [W-1:0]       y,
    input  logic [2*W-1:0]     z,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [ACC_W-1:0]   sum_ed,
    output logic [ACC_W:0]     sum_se,
    output logic [2*W-1:0]     max_ed,
    output logic [CNT_W-1:0]   err_cnt
);

    localparam int PW = 2 * W;
    localparam logic [ACC_W-1:0] ED_SAT = '1;
    localparam logic [ACC_W:0]   SE_MAX = {1'b0, {ACC_W{1'b1}}};
    localparam logic [ACC_W:0]   SE_MIN = {1'b1, {ACC_W{1'b0}}};
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(WINDOW - 1);

    typedef struct packed {
        logic [ACC_W-1:0] sum_ed;
        logic [ACC_W:0]   sum_se;
        logic [PW-1:0]    max_ed;
        logic [CNT_W-1:0] err_cnt;
    } rec_t;

    logic             accept, s1_valid, win_end;
    logic [PW-1:0]    s1_z, s1_exact, ed;
    logic [PW:0]      d;
    logic [CNT_W-1:0] smp_cnt;
    logic [ACC_W:0]   ed_sum;
    logic [ACC_W+1:0] se_sum;
    rec_t             acc, nxt, res;

    assign in_ready = !(res_valid && !res_ready) && !rst && !clr;
    assign accept   = in_valid && in_ready;
    assign win_end  = s1_valid && (smp_cnt == LAST);

    err_calc #(.PW(PW)) u_err (
        .z     (s1_z),
        .exact (s1_exact),
        .d     (d),
        .ed    (ed)
    );

    // Both sums are formed one bit wider than the accumulator; the extra bit flags overflow.
    always_comb begin
        nxt         = acc;
        ed_sum      = {1'b0, acc.sum_ed} + {{(ACC_W + 1 - PW){1'b0}}, ed};
        se_sum      = {acc.sum_se[ACC_W], acc.sum_se} + {{(ACC_W + 1 - PW){d[PW]}}, d};
        nxt.sum_ed  = ed_sum[ACC_W] ? ED_SAT : ed_sum[ACC_W-1:0];
        if (se_sum[ACC_W+1] != se_sum[ACC_W])
            nxt.sum_se = se_sum[ACC_W+1] ? SE_MIN : SE_MAX;
        else
            nxt.sum_se = se_sum[ACC_W:0];
        nxt.max_ed  = (ed > acc.max_ed) ? ed : acc.max_ed;
        nxt.err_cnt = acc.err_cnt + {{(CNT_W - 1){1'b0}}, |d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_z      <= '0;
            s1_exact  <= '0;
            acc       <= '0;
            smp_cnt   <= '0;
            res       <= '0;
            res_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_z     <= z;
                s1_exact <= x * y;
            end
            if (clr) begin
                s1_valid <= 1'b0;
                acc      <= '0;
                smp_cnt  <= '0;
            end else if (win_end) begin
                res     <= nxt;
                acc     <= '0;
                smp_cnt <= '0;
            end else if (s1_valid) begin
                acc     <= nxt;
                smp_cnt <= smp_cnt + 1'b1;
            end
            // A new window end on the handshake edge keeps the record valid.
            if (!clr && win_end)
                res_valid <= 1'b1;
            else if (res_valid && res_ready)
                res_valid <= 1'b0;
        end
    end

    assign sum_ed  = res.sum_ed;
    assign sum_se  = res.sum_se;
    assign max_ed  = res.max_ed;
    assign err_cnt = res.err_cnt;

endmodule
